fproc_arbiter: RTL

//  Shares one function-processor (fproc) port among N_CORES proc instances. Latches

---
 rtl/fproc_pkg.sv | 14 +
 rtl/fproc_arbiter_if.sv | 34 +++
 rtl/fproc_arbiter_rr_arbiter.sv | 35 +++
 rtl/fproc_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fproc_pkg.sv
// Shared definitions for the fproc arbiter slice.
//   FPROC_ID_WIDTH : default width of a function-processor request id
//   fparb_state_t  : arbiter sequencing state (IDLE waits for a pending
//                    request, WAIT holds one issued request until it completes)
package fproc_pkg;

    localparam int FPROC_ID_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fparb_state_t;

endpackage

// File: rtl/fproc_arbiter_if.sv
// Bundle of the core-side and fproc-side handshake signals of the arbiter.
//   core_enable / core_id : per-core request pulse and id (core i at [i*W+:W])
//   core_ready / core_data: per-core response pulse and held result
//   fp_enable / fp_id     : request pulse and held id towards the shared fproc
//   fp_ready / fp_data    : fproc response strobe and result
//   timeout_err           : sticky flag, set whenever a request was force-completed
// Modports: slave = arbiter view, master = view of the surrounding cores/fproc.
interface fproc_arbiter_if #(
    parameter int N_CORES        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int FPROC_ID_WIDTH = 8
);

    logic [N_CORES-1:0]                core_enable;
    logic [N_CORES*FPROC_ID_WIDTH-1:0] core_id;
    logic [N_CORES-1:0]                core_ready;
    logic [N_CORES*DATA_WIDTH-1:0]     core_data;
    logic                              fp_enable;
    logic [FPROC_ID_WIDTH-1:0]         fp_id;
    logic                              fp_ready;
    logic [DATA_WIDTH-1:0]             fp_data;
    logic                              timeout_err;

    modport slave (
        input  core_enable, core_id, fp_ready, fp_data,
        output core_ready, core_data, fp_enable, fp_id, timeout_err
    );

    modport master (
        output core_enable, core_id, fp_ready, fp_data,
        input  core_ready, core_data, fp_enable, fp_id, timeout_err
    );

endinterface

// File: rtl/fproc_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req     : request vector, one bit per requester
//   ptr     : index of the requester served last
//   gnt_idx : first requesting index after ptr, wrapping (ptr+1, ptr+2, ...)
//   any     : at least one request is present (gnt_idx is meaningful only then)
// Holds no state; the pointer lives in the caller.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] cand;

    // The requester at ptr itself is scanned last, so whoever was just served
    // only wins again when nobody else is waiting.
    always_comb begin
        gnt_idx = ptr;
        any     = 1'b0;
        cand    = '0;
        for (int off = 1; off <= N; off++) begin
            cand = IDX_W'((int'(ptr) + off) % N);
            if (!any && req[cand]) begin
                any     = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/fproc_arbiter.sv
// Shares one function-processor port among N_CORES proc cores.
// Each core's request (enable + id) is latched, requests are granted one at a
// time in round-robin order, issued to the shared fproc, and the result plus a
// one-cycle ready pulse are returned to the requesting core.
//   clk   : clock, all flops on the rising edge
//   reset : asynchronous, active-low
//   bus   : fproc_arbiter_if slave modport (core side and fproc side)
// TIMEOUT_CYCLES bounds the time spent waiting on the fproc (0 disables it);
// a forced completion returns all-ones data and sets the sticky timeout_err.
module fproc_arbiter
    import fproc_pkg::*;
#(
    parameter int N_CORES        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int FPROC_ID_WIDTH = fproc_pkg::FPROC_ID_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic           clk,
    input logic           reset,
    fproc_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(N_CORES);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_CORE = IDX_W'(N_CORES - 1);

    fparb_state_t                  state, state_next;
    logic [IDX_W-1:0]              grant, grant_next;
    logic [IDX_W-1:0]              rr_ptr, rr_ptr_next;
    logic [CNT_W-1:0]              tmo_cnt, tmo_cnt_next;
    logic [N_CORES-1:0]            pend, pend_clr, capture;
    logic [FPROC_ID_WIDTH-1:0]     pend_id [N_CORES];

    logic                          fp_enable_q, fp_enable_next;
    logic [FPROC_ID_WIDTH-1:0]     fp_id_q, fp_id_next;
    logic [N_CORES-1:0]            core_ready_q, core_ready_next;
    logic [N_CORES*DATA_WIDTH-1:0] core_data_q;
    logic                          timeout_err_q;

    logic                          resp_fire;
    logic [DATA_WIDTH-1:0]         resp_data;
    logic                          timeout_hit, timeout_set;
    logic [IDX_W-1:0]              arb_idx;
    logic                          arb_any;

    rr_arbiter #(.N(N_CORES)) u_rr (
        .req     (pend),
        .ptr     (rr_ptr),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // The counter starts at zero in the first WAIT cycle, so a match against
    // TIMEOUT_CYCLES-1 ends the wait after exactly TIMEOUT_CYCLES WAIT cycles.
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // A completing core that re-requests on the same edge keeps its new request.
    assign capture = bus.core_enable & (~pend | pend_clr);

    always_comb begin
        state_next      = state;
        grant_next      = grant;
        rr_ptr_next     = rr_ptr;
        tmo_cnt_next    = tmo_cnt;
        fp_enable_next  = 1'b0;
        fp_id_next      = fp_id_q;
        core_ready_next = '0;
        pend_clr        = '0;
        resp_fire       = 1'b0;
        resp_data       = bus.fp_data;
        timeout_set     = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    state_next     = WAIT;
                    grant_next     = arb_idx;
                    fp_enable_next = 1'b1;
                    fp_id_next     = pend_id[arb_idx];
                    tmo_cnt_next   = '0;
                end
            end
            WAIT: begin
                // A real response beats a timeout falling on the same cycle.
                if (bus.fp_ready) begin
                    resp_fire = 1'b1;
                end else if (timeout_hit) begin
                    resp_fire   = 1'b1;
                    resp_data   = '1;
                    timeout_set = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt + CNT_W'(1);
                end
                if (resp_fire) begin
                    state_next             = IDLE;
                    core_ready_next[grant] = 1'b1;
                    pend_clr[grant]        = 1'b1;
                    rr_ptr_next            = grant;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            grant         <= '0;
            rr_ptr        <= LAST_CORE;
            tmo_cnt       <= '0;
            fp_enable_q   <= 1'b0;
            fp_id_q       <= '0;
            core_ready_q  <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state         <= state_next;
            grant         <= grant_next;
            rr_ptr        <= rr_ptr_next;
            tmo_cnt       <= tmo_cnt_next;
            fp_enable_q   <= fp_enable_next;
            fp_id_q       <= fp_id_next;
            core_ready_q  <= core_ready_next;
            timeout_err_q <= timeout_err_q | timeout_set;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= '0;
            for (int i = 0; i < N_CORES; i++) begin
                pend_id[i] <= '0;
            end
        end else begin
            pend <= (pend & ~pend_clr) | capture;
            for (int i = 0; i < N_CORES; i++) begin
                if (capture[i]) begin
                    pend_id[i] <= bus.core_id[i*FPROC_ID_WIDTH +: FPROC_ID_WIDTH];
                end
            end
        end
    end

    // Each core's result is held until that core's next completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_data_q <= '0;
        end else if (resp_fire) begin
            core_data_q[int'(grant)*DATA_WIDTH +: DATA_WIDTH] <= resp_data;
        end
    end

    assign bus.fp_enable   = fp_enable_q;
    assign bus.fp_id       = fp_id_q;
    assign bus.core_ready  = core_ready_q;
    assign bus.core_data   = core_data_q;
    assign bus.timeout_err = timeout_err_q;

endmodule
